uart_transmitter: RTL and testbench
===================================

# uart_transmitter

Serial transmitter for the team's UART link, the sending end paired with our UART receiver. Accepts parallel bytes over a valid/ready handshake and serialises each as one start bit (0), eight data bits LSB first, and one stop bit (1). A one-entry holding register lets the next byte queue during a frame, so frames go out back-to-back. Line idles high.

## Interface
- CLKS_PER_BIT, default 1: clock cycles each line bit is held. Legal range 1..65535. Default 1 matches the receiver's one-bit-per-clock sampling.
- i_clk  input  1  system clock; all logic on posedge.
- i_rst  input  1  reset, asynchronous, active-low. Asserting it clears all state immediately.
- i_data  input  8  byte to send. Sampled only on a handshake.
- i_valid  input  1  i_data is valid.
- o_ready  output  1  holding register is empty; the byte is accepted when i_valid && o_ready at a posedge.
- o_data  output  1  serial line, registered.
- o_busy  output  1  high while a frame (start..stop) is on the line.
- o_done  output  1  one-cycle pulse in the last cycle of each stop bit.

## Operation
- Reset values: o_data=1, o_ready=1, o_busy=0, o_done=0. FSM=IDLE, holding register empty, counters=0.
- FSM states:
  - IDLE: line high.
  - START: line 0.
  - DATA: d0..d7, 3-bit index.
  - PARITY: only with the macro; see Configuration.
  - STOP: line 1.
- Baud counter counts 0..CLKS_PER_BIT-1 and is $clog2-sized, minimum 1 bit. A state or bit advances when the counter hits its terminal value. The counter then wraps to 0.
- Handshake writes the holding register. o_ready drops the cycle after acceptance.
- IDLE with holding register full: load the shift register from the holding register, free it (o_ready=1 next cycle), and go to START.
- DATA: bit index 0..7. After bit 7 go to STOP, or to PARITY if enabled.
- STOP terminal cycle: assert o_done.
  - If the holding register is full, load it and go directly to START, with no idle bit.
  - Otherwise go to IDLE.
- Accept and load in the same cycle (IDLE with buffer full while a new handshake occurs) cannot happen, because o_ready=0 while the buffer is full.
- A handshake during a frame is legal. It never disturbs the frame in flight.
- i_data changes while not accepted are ignored.
- Reset mid-frame: line returns to 1 asynchronously, the frame is abandoned, and the queued byte is discarded.

## Timing
- Handshake at posedge N with transmitter IDLE and buffer empty:
  - Byte reaches the holding register at N.
  - Loaded and START entered at N+1.
  - o_data=0 and o_busy=1 visible after posedge N+1.
- Frame length is 10×CLKS_PER_BIT cycles (11× with parity).
- o_busy falls the cycle after the final stop cycle when nothing is queued. It stays high across back-to-back frames.
- Sustained throughput: one byte per frame time, with no idle gap when the producer keeps the buffer full.
- o_ready returns high one cycle after the byte moves into the shift register.

## Configuration
- UART_TX_PARITY_EN defined: an even-parity bit (XOR of d0..d7) is sent between d7 and stop, making an 11-bit frame.
- Undefined: there is no PARITY state and the frame is 10 bits. This is the default, matching the receiver's 10-bit framing.

## Test plan
- Reset: hold i_rst=0 for 3 cycles → o_data=1, o_ready=1, o_busy=0, o_done=0.
- Single byte, CLKS_PER_BIT=1, send 0xA5 → o_data from N+1 is 0,1,0,1,0,0,1,0,1,1, then 1 idle. o_done pulses on the 10th bit.
- Back-to-back: send 0x3C, then 0xFF while the first frame is in flight → second start bit immediately follows the first stop bit, with no idle cycle. o_busy stays high for 20 cycles.
- Baud: CLKS_PER_BIT=4, send 0x01 → each bit held exactly 4 cycles; total frame 40 cycles.
- Reset mid-frame: assert i_rst during d3 of 0x55 with a byte queued → o_data=1 at once. After release there is no output until a new handshake.
- Parity build (UART_TX_PARITY_EN), send 0x07 → bit 10 = 1, then stop. Send 0x03 → bit 10 = 0.

Source files
------------

// File: rtl/uart_transmitter.sv
// Serialises bytes as start, d0..d7 LSB first, stop; a one-byte holding register lets the next frame follow with no gap.
// Define UART_TX_PARITY_EN to insert an even-parity bit between d7 and stop (11-bit frame).
module uart_transmitter #(
  parameter int unsigned CLKS_PER_BIT = 1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_data,
  input  logic       i_valid,
  output logic       o_ready,
  output logic       o_data,
  output logic       o_busy,
  output logic       o_done
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    hold_q, hold_d;
  logic          full_q, full_d;
  logic          line_q, line_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          bit_end;
  logic          load;
`ifdef UART_TX_PARITY_EN
  logic          par_q, par_d;
`endif

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      hold_q  <= '0;
      full_q  <= 1'b0;
      line_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      hold_q  <= hold_d;
      full_q  <= full_d;
      line_q  <= line_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    hold_d  = hold_q;
    full_d  = full_q;
    load    = 1'b0;
    bit_end = (cnt_q == CNT_LAST);
    cnt_d   = bit_end ? '0 : cnt_q + 1'b1;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif

    // Accept only into an empty holding register; a full one is never both loaded and written.
    if (i_valid && !full_q) begin
      hold_d = i_data;
      full_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        load  = full_q;
      end
      START: if (bit_end) begin
        state_d = DATA;
        idx_d   = '0;
      end
      DATA: if (bit_end) begin
        if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end else begin
          idx_d   = idx_q + 3'd1;
          shift_d = {1'b0, shift_q[7:1]};
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (bit_end) state_d = STOP;
`endif
      STOP: if (bit_end) begin
        if (full_q) load = 1'b1;
        else        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      state_d = START;
      cnt_d   = '0;
      idx_d   = '0;
      shift_d = hold_q;
      full_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_d   = ^hold_q;
`endif
    end
  end

  // Outputs are registered from the next state so the line changes exactly at the bit boundary.
  always_comb begin
    line_d = 1'b1;
    case (state_d)
      START:   line_d = 1'b0;
      DATA:    line_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  line_d = par_d;
`endif
      default: line_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == STOP) && (cnt_d == CNT_LAST);
  end

  assign o_ready = !full_q;
  assign o_data  = line_q;
  assign o_busy  = busy_q;
  assign o_done  = done_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Scoreboard bench: two transmitters (1 and 4 clocks per bit); expected per-cycle {busy,data,done} queued at stimulus time.
module tb_uart_transmitter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] dat0, dat1;
  logic       vld0, vld1;
  logic       rdy0, rdy1, txd0, txd1, busy0, busy1, done0, done1;
  logic [1:0] mon_en;
  logic [2:0] q0[$];
  logic [2:0] q1[$];
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  uart_transmitter #(.CLKS_PER_BIT(1)) u_dut0 (
    .i_clk(clk), .i_rst(rst_n), .i_data(dat0), .i_valid(vld0),
    .o_ready(rdy0), .o_data(txd0), .o_busy(busy0), .o_done(done0)
  );

  uart_transmitter #(.CLKS_PER_BIT(4)) u_dut1 (
    .i_clk(clk), .i_rst(rst_n), .i_data(dat1), .i_valid(vld1),
    .o_ready(rdy1), .o_data(txd1), .o_busy(busy1), .o_done(done1)
  );

  function automatic void push(input int d, input logic [2:0] e);
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endfunction

  // One entry per clock: {busy, line, done}. Idle is 3'b010.
  function automatic void push_frame(input int d, input logic [7:0] b, input int cpb);
    logic [10:0] bits;
    int n;
`ifdef UART_TX_PARITY_EN
    bits = {1'b1, ^b, b, 1'b0};
    n = 11;
`else
    bits = {1'b1, 1'b1, b, 1'b0};
    n = 10;
`endif
    for (int i = 0; i < n; i++)
      for (int c = 0; c < cpb; c++)
        push(d, {1'b1, bits[i], (i == n - 1) && (c == cpb - 1)});
  endfunction

  task automatic mon_step(input int d, input logic b, input logic x, input logic dn);
    logic [2:0] e;
    logic [2:0] a;
    a = {b, x, dn};
    e = 3'b010;
    if (d == 0 && q0.size() > 0) e = q0.pop_front();
    else if (d == 1 && q1.size() > 0) e = q1.pop_front();
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL mon%0d busy/data/done got=%b exp=%b t=%0t", d, a, e, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en[0]) mon_step(0, busy0, txd0, done0);
    if (mon_en[1]) mon_step(1, busy1, txd1, done1);
  end

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%b exp=%b", name, act, exp);
    end
  endtask

  function automatic logic rdy(input int d);
    return (d == 0) ? rdy0 : rdy1;
  endfunction

  // Returns just after the accepting posedge.
  task automatic send(input int d, input logic [7:0] b);
    int k;
    @(negedge clk);
    if (d == 0) begin vld0 = 1'b1; dat0 = b; end
    else        begin vld1 = 1'b1; dat1 = b; end
    k = 0;
    while (!rdy(d) && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) chk("ready_timeout", 1'b0, 1'b1);
    @(posedge clk);
    #1;
    if (d == 0) begin vld0 = 1'b0; dat0 = 8'h00; end
    else        begin vld1 = 1'b0; dat1 = 8'h00; end
  endtask

  task automatic drain(input int d);
    int k;
    k = 0;
    while (((d == 0) ? q0.size() : q1.size()) > 0 && k < 1000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 1000) chk("drain_timeout", 1'b0, 1'b1);
    repeat (3) @(negedge clk);
  endtask

  task automatic single(input int d, input logic [7:0] b, input int cpb);
    send(d, b);
    push(d, 3'b010);
    push_frame(d, b, cpb);
    drain(d);
  endtask

  initial begin
    rst_n = 1'b0; vld0 = 1'b0; vld1 = 1'b0; dat0 = 8'h00; dat1 = 8'h00; mon_en = 2'b00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_data0", txd0, 1'b1);   chk("rst_ready0", rdy0, 1'b1);
    chk("rst_busy0", busy0, 1'b0);  chk("rst_done0", done0, 1'b0);
    chk("rst_data1", txd1, 1'b1);   chk("rst_ready1", rdy1, 1'b1);
    chk("rst_busy1", busy1, 1'b0);  chk("rst_done1", done1, 1'b0);
    rst_n = 1'b1;
    #1 mon_en = 2'b11;

    single(0, 8'hA5, 1);
    single(1, 8'h01, 4);

    // Back-to-back: second byte queued mid-frame, second start right after first stop.
    send(0, 8'h3C);
    push(0, 3'b010);
    push_frame(0, 8'h3C, 1);
    push_frame(0, 8'hFF, 1);
    send(0, 8'hFF);
    drain(0);

    single(0, 8'h07, 1);
    single(0, 8'h03, 1);
    single(1, 8'hC3, 4);

    // Reset during d3 of 0x55 with 0xAA queued.
    mon_en[0] = 1'b0;
    send(0, 8'h55);
    send(0, 8'hAA);
    repeat (3) @(posedge clk);
    #1;
    chk("pre_reset_d3", txd0, 1'b0);
    chk("pre_reset_busy", busy0, 1'b1);
    chk("pre_reset_ready", rdy0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst_data", txd0, 1'b1);
    chk("midrst_busy", busy0, 1'b0);
    chk("midrst_ready", rdy0, 1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    q0.delete();
    #1 mon_en[0] = 1'b1;
    repeat (30) @(negedge clk);

    single(0, 8'h81, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
